// File: rtl/traffic_pkg.sv
// traffic_pkg
//   Shared definitions for the traffic-lights controller and its pedestrian
//   request front end.
//   - req_state_e : request FSM encodings (IDLE=0, REQ=1, SERVE=2, COOL=3)
//   - DEBOUNCE_CYCLES / COOLDOWN_CYCLES : default timing constants
//   - ctrl_mode_e : controller mode encodings; MODE0 is the pedestrian
//                   (all-lights-off) phase
//   - cnt_width() : width of a counter that must hold 0..n (never below 1)
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_SERVE = 2'd2,
        ST_COOL  = 2'd3
    } req_state_e;

    localparam int DEBOUNCE_CYCLES = 4;
    localparam int COOLDOWN_CYCLES = 30;

    typedef enum logic [1:0] {
        MODE0 = 2'd0,
        MODE1 = 2'd1,
        MODE2 = 2'd2,
        MODE3 = 2'd3
    } ctrl_mode_e;

    function automatic logic is_ped_phase(input ctrl_mode_e mode);
        return mode == MODE0;
    endfunction

    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ped_request_conditioner_debouncer.sv
// button_debouncer
//   Two-flop synchroniser followed by a debounce counter. The debounced level
//   only follows the synchronised input after it has differed for
//   DEBOUNCE_CYCLES consecutive cycles; a registered one-cycle pulse marks
//   each 0->1 change of the debounced level.
//   Ports:
//     clk        in  system clock
//     reset      in  asynchronous, active-high reset
//     btn_raw_i  in  raw push-button (asynchronous, may bounce)
//     press_p_o  out one-cycle pulse on an accepted press
module button_debouncer
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = traffic_pkg::DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw_i,
    output logic press_p_o
);

    localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

    logic            s1_q;
    logic            btn_s_q;
    logic            db_lvl_q, db_lvl_d;
    logic            press_q, press_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;

    // The counter runs only while the synchronised input disagrees with the
    // debounced level; any agreement restarts the stability window.
    always_comb begin
        db_lvl_d = db_lvl_q;
        db_cnt_d = '0;
        press_d  = 1'b0;
        if (btn_s_q != db_lvl_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_lvl_d = btn_s_q;
                press_d  = btn_s_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q     <= 1'b0;
            btn_s_q  <= 1'b0;
            db_lvl_q <= 1'b0;
            db_cnt_q <= '0;
            press_q  <= 1'b0;
        end else begin
            s1_q     <= btn_raw_i;
            btn_s_q  <= s1_q;
            db_lvl_q <= db_lvl_d;
            db_cnt_q <= db_cnt_d;
            press_q  <= press_d;
        end
    end

    assign press_p_o = press_q;

endmodule

// File: rtl/ped_request_conditioner.sv
// ped_request_conditioner
//   Turns the raw pedestrian push-button into a held request level for the
//   traffic-lights controller. A debounced press latches one request, held
//   until the controller's pedestrian phase is seen; after that phase ends a
//   cooldown window ignores further presses.
//   Ports:
//     clk          in   system clock
//     reset        in   asynchronous, active-high reset
//     btn_raw      in   raw push-button (asynchronous, may bounce)
//     ped_phase    in   controller is in its pedestrian (all-lights-off) phase
//     button       out  request level to the controller
//     busy         out  request FSM is not idle
//     press_count  out  accepted requests, saturating
//
//   state | meaning
//   IDLE  | no request; a press pulse is accepted and counted
//   REQ   | request held to the controller; extra presses merge
//   SERVE | pedestrian phase in progress; waiting for it to end
//   COOL  | cooldown after service; presses dropped
module ped_request_conditioner
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = traffic_pkg::DEBOUNCE_CYCLES,
    parameter int COOLDOWN_CYCLES = traffic_pkg::COOLDOWN_CYCLES,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_raw,
    input  logic             ped_phase,
    output logic             button,
    output logic             busy,
    output logic [CNT_W-1:0] press_count
);

    localparam int CL_W = cnt_width(COOLDOWN_CYCLES);
    localparam logic [CL_W-1:0] COOL_LOAD = CL_W'(COOLDOWN_CYCLES);
    localparam logic [CL_W-1:0] COOL_ONE  = CL_W'(1);

    req_state_e       state_q, state_d;
    logic [CL_W-1:0]  cool_cnt_q, cool_cnt_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             button_q, button_d;
    logic             press_p;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk       (clk),
        .reset     (reset),
        .btn_raw_i (btn_raw),
        .press_p_o (press_p)
    );

    always_comb begin
        state_d    = state_q;
        cool_cnt_d = cool_cnt_q;
        count_d    = count_q;
        case (state_q)
            ST_IDLE: begin
                if (press_p) begin
                    state_d = ST_REQ;
                    if (count_q != '1) begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            ST_REQ: begin
                if (ped_phase) begin
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (!ped_phase) begin
                    if (COOLDOWN_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d    = ST_COOL;
                        cool_cnt_d = COOL_LOAD;
                    end
                end
            end
            ST_COOL: begin
                // Exit on the count of one so COOL spans exactly the loaded number of cycles.
                if (cool_cnt_q == COOL_ONE) begin
                    state_d    = ST_IDLE;
                    cool_cnt_d = '0;
                end else begin
                    cool_cnt_d = cool_cnt_q - COOL_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Registered so the controller sees a glitch-free request level.
        button_d = (state_d == ST_REQ);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cool_cnt_q <= '0;
            count_q    <= '0;
            button_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cool_cnt_q <= cool_cnt_d;
            count_q    <= count_d;
            button_q   <= button_d;
        end
    end

    assign button      = button_q;
    assign busy        = (state_q != ST_IDLE);
    assign press_count = count_q;

endmodule

// File: tb/tb_ped_request_conditioner.sv
// tb_ped_request_conditioner
//   Drives the pedestrian request conditioner with directed scenarios and
//   random button/phase activity. A behavioural model predicts button, busy
//   and press_count after every clock edge and queues the prediction; a
//   monitor pops one prediction per cycle on the falling edge and compares.
module tb_ped_request_conditioner;

    localparam int DB   = 4;
    localparam int CD   = 6;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          btn_raw   = 1'b1;
    logic          ped_phase = 1'b0;
    logic          button;
    logic          busy;
    logic [CW-1:0] press_count;

    ped_request_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .COOLDOWN_CYCLES(CD),
        .CNT_W          (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .ped_phase  (ped_phase),
        .button     (button),
        .busy       (busy),
        .press_count(press_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          button;
        logic          busy;
        logic [CW-1:0] count;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Behavioural model: raw sample history, a run length of disagreement
    // for the debounce, and request bookkeeping as flags plus a remaining
    // cooldown count.
    bit m_s1, m_bs, m_lvl, m_pulse;
    bit m_pending, m_serving;
    int m_run, m_cool, m_count;

    task automatic check(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, want, $time);
        end
    endtask

    function automatic void model_reset();
        m_s1 = 0; m_bs = 0; m_lvl = 0; m_pulse = 0;
        m_pending = 0; m_serving = 0;
        m_run = 0; m_cool = 0; m_count = 0;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.button = m_pending;
        e.busy   = m_pending | m_serving | (m_cool > 0);
        e.count  = CW'(m_count);
        return e;
    endfunction

    function automatic void model_edge(input bit r, input bit p);
        // Request bookkeeping reacts to the pulse visible before this edge.
        if (m_pending) begin
            if (p) begin m_pending = 0; m_serving = 1; end
        end else if (m_serving) begin
            if (!p) begin m_serving = 0; m_cool = CD; end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (m_pulse) begin
            m_pending = 1;
            if (m_count < CMAX) m_count++;
        end
        // Debounce: level follows after DB consecutive cycles of disagreement.
        m_pulse = 0;
        if (m_bs != m_lvl) begin
            m_run++;
            if (m_run == DB) begin
                m_lvl   = m_bs;
                m_pulse = m_bs;
                m_run   = 0;
            end
        end else begin
            m_run = 0;
        end
        m_bs = m_s1;
        m_s1 = r;
    endfunction

    // One clock: drive inputs, take the edge, queue the prediction.
    task automatic step(input bit r, input bit p, input bit rst);
        btn_raw   = r;
        ped_phase = p;
        reset     = rst;
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge(r, p);
        exp_q.push_back(model_out());
        #1;
    endtask

    task automatic steps(input int n, input bit r, input bit p);
        for (int i = 0; i < n; i++) step(r, p, 1'b0);
    endtask

    // Reset asserted between edges; the pending prediction becomes the reset values.
    task automatic async_reset();
        reset = 1'b1;
        model_reset();
        exp_q.delete();
        exp_q.push_back(model_out());
        #1;
    endtask

    task automatic serve();
        steps(3, 1'b0, 1'b1);
        steps(CD + 4, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("button", int'(button), int'(e.button));
                check("busy", int'(busy), int'(e.busy));
                check("press_count", int'(press_count), int'(e.count));
            end
        end
    end

    initial begin : driver
        int rise_at;
        int busy_len;

        // 1: reset held with button pressed, then release latency
        model_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
        rise_at = -1;
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (button && rise_at < 0) rise_at = i - 1;
        end
        check("reset_release_latency", rise_at, 6);
        steps(8, 1'b0, 1'b0);
        serve();

        // 2: bounce never produces a request
        async_reset();
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(i[0] ? 1'b0 : 1'b1, 1'b0, 1'b0);
        steps(10, 1'b0, 1'b0);
        check("bounce_count", int'(press_count), 0);
        check("bounce_button", int'(button), 0);

        // 3: clean press, service, exact cooldown length
        steps(10, 1'b1, 1'b0);
        check("clean_button", int'(button), 1);
        check("clean_count", int'(press_count), 1);
        steps(5, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("serve_button_drop", int'(button), 0);
        steps(2, 1'b0, 1'b1);
        busy_len = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (busy) busy_len++;
            else break;
        end
        check("cooldown_busy_len", busy_len, CD);

        // 4: merge a second press in REQ, drop a press during COOL
        async_reset();
        step(1'b0, 1'b0, 1'b1);
        steps(10, 1'b1, 1'b0);
        steps(8, 1'b0, 1'b0);
        steps(10, 1'b1, 1'b0);
        steps(8, 1'b0, 1'b0);
        check("merge_count", int'(press_count), 1);
        check("merge_button", int'(button), 1);
        steps(3, 1'b0, 1'b1);
        steps(14, 1'b1, 1'b0);
        check("cool_drop_count", int'(press_count), 1);
        check("cool_drop_button", int'(button), 0);
        check("cool_drop_busy", int'(busy), 0);
        steps(8, 1'b0, 1'b0);
        steps(8, 1'b1, 1'b0);
        check("repress_count", int'(press_count), 2);
        steps(8, 1'b0, 1'b0);
        serve();

        // random button and phase activity
        for (int seg = 0; seg < 250; seg++) begin
            bit r, p;
            int len;
            len = int'($urandom_range(1, 10));
            r   = 1'($urandom_range(0, 1));
            p   = ($urandom_range(0, 3) == 0);
            steps(len, r, p);
        end
        steps(8, 1'b0, 1'b0);
        serve();

        // 6: asynchronous reset in the middle of a held request
        steps(8, 1'b1, 1'b0);
        check("pre_reset_button", int'(button), 1);
        async_reset();
        check("async_button", int'(button), 0);
        check("async_busy", int'(busy), 0);
        check("async_count", int'(press_count), 0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        steps(4, 1'b0, 1'b0);

        // 5: saturation over 300 full service cycles
        for (int n = 0; n < 300; n++) begin
            steps(6, 1'b1, 1'b0);
            steps(6, 1'b0, 1'b0);
            serve();
        end
        check("sat_count", int'(press_count), CMAX);

        steps(2, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
